// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants and state type for the 4x4 keypad scanner.
// Optional auto-repeat is enabled by defining KEYPAD_REPEAT_EN.
package keypad_pkg;

  localparam int NUM_ROWS   = 4;
  localparam int NUM_COLS   = 4;
  localparam int KEY_CODE_W = 4;
  localparam int COL_W      = $clog2(NUM_COLS);
  localparam int ROW_W      = $clog2(NUM_ROWS);

  // Active-low strobe pattern for column 0
  localparam logic [NUM_COLS-1:0] COL0_STROBE = 4'b1110;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_t;

endpackage

// File: rtl/keypad_scan_timer.sv
// keypad_scan_timer: slot/column counters, column strobe decode and
// the sample / frame-end / frame-start pulses for the keypad scan.
module keypad_scan_timer
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic                i_clk,
  input  logic                i_rst,
  output logic [COL_W-1:0]    o_col_idx,
  output logic [NUM_COLS-1:0] o_key_col,
  output logic                o_sample,
  output logic                o_frame_end,
  output logic                o_frame_start
);

  localparam int SLOT_W = $clog2(SCAN_DIV);

  logic [SLOT_W-1:0] r_slot;
  logic [COL_W-1:0]  r_col;
  logic              w_slot_last;

  assign w_slot_last = (r_slot == SLOT_W'(SCAN_DIV - 1));

  // Slot counter wraps every SCAN_DIV cycles and steps the column
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_slot <= '0;
      r_col  <= '0;
    end else if (w_slot_last) begin
      r_slot <= '0;
      r_col  <= r_col + COL_W'(1);
    end else begin
      r_slot <= r_slot + SLOT_W'(1);
    end
  end

  assign o_col_idx     = r_col;
  assign o_key_col     = ~((~COL0_STROBE) << r_col);
  assign o_sample      = w_slot_last;
  assign o_frame_end   = w_slot_last
                       && (r_col == COL_W'(NUM_COLS - 1));
  assign o_frame_start = (r_slot == '0) && (r_col == '0);

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad, debounces per frame
// and reports one key at a time. Define KEYPAD_REPEAT_EN for auto-repeat.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int REPEAT_DELAY    = 150,
  parameter int REPEAT_RATE     = 25
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NUM_ROWS-1:0]   KEY_ROW,
  output logic [NUM_COLS-1:0]   KEY_COL,
  output logic [KEY_CODE_W-1:0] KEY_CODE,
  output logic                  KEY_VALID,
  output logic                  KEY_HELD
);

  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);

  logic [COL_W-1:0]      w_col;
  logic                  w_sample;
  logic                  w_frame_end;
  logic                  w_frame_start;

  logic [NUM_ROWS-1:0]   r_row_s1;
  logic [NUM_ROWS-1:0]   r_row_s2;
  logic [NUM_ROWS-1:0]   w_hits;
  logic [ROW_W-1:0]      w_row_idx;
  logic                  w_row_any;
  logic [KEY_CODE_W-1:0] w_hit_code;
  logic                  w_cand_now;

  logic                  r_frame_hit;
  logic [KEY_CODE_W-1:0] r_frame_code;
  logic                  r_cand_seen;
  logic                  w_frame_hit;
  logic [KEY_CODE_W-1:0] w_frame_code;
  logic                  w_cand_seen;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [KEY_CODE_W-1:0] r_cand;
  logic                  w_cnt_last;

  keypad_scan_timer #(
    .SCAN_DIV (SCAN_DIV)
  ) u_timer (
    .i_clk         (CLK),
    .i_rst         (RST),
    .o_col_idx     (w_col),
    .o_key_col     (KEY_COL),
    .o_sample      (w_sample),
    .o_frame_end   (w_frame_end),
    .o_frame_start (w_frame_start)
  );

  // Two-flop synchronizer for the asynchronous row lines
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_row_s1 <= '1;
      r_row_s2 <= '1;
    end else begin
      r_row_s1 <= KEY_ROW;
      r_row_s2 <= r_row_s1;
    end
  end

  assign w_hits    = ~r_row_s2;
  assign w_row_any = |w_hits;

  // Lowest pressed row in the column being sampled
  always_comb begin
    w_row_idx = '0;
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      if (w_hits[r]) w_row_idx = ROW_W'(r);
    end
  end

  assign w_hit_code = {w_row_idx, w_col};
  assign w_cand_now = (w_col == r_cand[COL_W-1:0])
                    && w_hits[r_cand[KEY_CODE_W-1:COL_W]];

  // Frame view including the sample taken on this cycle
  assign w_frame_hit  = r_frame_hit | (w_sample & w_row_any);
  assign w_frame_code = r_frame_hit ? r_frame_code : w_hit_code;
  assign w_cand_seen  = r_cand_seen | (w_sample & w_cand_now);

  // Per-frame accumulation, cleared at the start of each frame
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_frame_hit  <= 1'b0;
      r_frame_code <= '0;
      r_cand_seen  <= 1'b0;
    end else if (w_frame_start) begin
      r_frame_hit  <= 1'b0;
      r_frame_code <= '0;
      r_cand_seen  <= 1'b0;
    end else if (w_sample) begin
      r_frame_hit  <= w_frame_hit;
      r_frame_code <= w_frame_code;
      r_cand_seen  <= w_cand_seen;
    end
  end

  assign w_cnt_last = (r_cnt == CNT_W'(DEBOUNCE_FRAMES - 1));

`ifdef KEYPAD_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE)
                         ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] r_rpt;
  logic             r_rpt_armed;
  logic [RPT_W-1:0] w_rpt_next;
  logic             w_rpt_fire;

  assign w_rpt_next = r_rpt + RPT_W'(1);
  assign w_rpt_fire =
    (!r_rpt_armed && (w_rpt_next == RPT_W'(REPEAT_DELAY)))
    || (r_rpt_armed && (w_rpt_next == RPT_W'(REPEAT_RATE)));
`else
  logic w_unused_rpt;
  assign w_unused_rpt = ^{32'(REPEAT_DELAY), 32'(REPEAT_RATE)};
`endif

  // Debounce/press FSM, stepped once per frame end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_cand    <= '0;
      KEY_CODE  <= '0;
      KEY_VALID <= 1'b0;
      KEY_HELD  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_rpt       <= '0;
      r_rpt_armed <= 1'b0;
`endif
    end else begin
      KEY_VALID <= 1'b0;
      if (w_frame_end) begin
        unique case (r_state)
          IDLE: begin
            if (w_frame_hit) begin
              r_cand <= w_frame_code;
              if (DEBOUNCE_FRAMES == 1) begin
                KEY_CODE  <= w_frame_code;
                KEY_VALID <= 1'b1;
                KEY_HELD  <= 1'b1;
                r_cnt     <= '0;
                r_state   <= PRESSED;
`ifdef KEYPAD_REPEAT_EN
                r_rpt       <= '0;
                r_rpt_armed <= 1'b0;
`endif
              end else begin
                r_cnt   <= CNT_W'(1);
                r_state <= DEBOUNCE;
              end
            end
          end
          DEBOUNCE: begin
            if (!w_cand_seen) begin
              r_cnt   <= '0;
              r_state <= IDLE;
            end else if (w_cnt_last) begin
              KEY_CODE  <= r_cand;
              KEY_VALID <= 1'b1;
              KEY_HELD  <= 1'b1;
              r_cnt     <= '0;
              r_state   <= PRESSED;
`ifdef KEYPAD_REPEAT_EN
              r_rpt       <= '0;
              r_rpt_armed <= 1'b0;
`endif
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          PRESSED: begin
            if (!w_cand_seen) begin
              if (DEBOUNCE_FRAMES == 1) begin
                KEY_HELD <= 1'b0;
                r_cnt    <= '0;
                r_state  <= IDLE;
              end else begin
                r_cnt   <= CNT_W'(1);
                r_state <= RELEASE;
              end
            end
`ifdef KEYPAD_REPEAT_EN
            else if (w_rpt_fire) begin
              KEY_VALID   <= 1'b1;
              r_rpt       <= '0;
              r_rpt_armed <= 1'b1;
            end else begin
              r_rpt <= w_rpt_next;
            end
`endif
          end
          RELEASE: begin
            if (w_cand_seen) begin
              r_state <= PRESSED;
            end else if (w_cnt_last) begin
              KEY_HELD <= 1'b0;
              r_cnt    <= '0;
              r_state  <= IDLE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: frame-aligned directed and random key patterns
// checked against a frame-level behavioural model of the keypad rules.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DF = 3;
  localparam int RD = 5;
  localparam int RR = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] KEY_ROW;
  logic [3:0] KEY_COL;
  logic [3:0] KEY_CODE;
  logic       KEY_VALID;
  logic       KEY_HELD;

  logic [15:0] keys = '0;

  int checks   = 0;
  int failures = 0;

  int m_st   = 0;
  int m_cnt  = 0;
  int m_cand = 0;
  int m_code = 0;
  int m_held = 0;
  int m_pfr  = 0;
  int dut_pulses = 0;

  always #5 CLK = ~CLK;

  // Physical keypad: a pressed key shorts its row to its column
  always_comb begin
    KEY_ROW = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !KEY_COL[c]) KEY_ROW[r] = 1'b0;
  end

  keypad_scanner #(
    .SCAN_DIV        (SD),
    .DEBOUNCE_FRAMES (DF),
    .REPEAT_DELAY    (RD),
    .REPEAT_RATE     (RR)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .KEY_ROW   (KEY_ROW),
    .KEY_COL   (KEY_COL),
    .KEY_CODE  (KEY_CODE),
    .KEY_VALID (KEY_VALID),
    .KEY_HELD  (KEY_HELD)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_cand = 0;
    m_code = 0; m_held = 0; m_pfr = 0;
  endtask

  task automatic model_accept(output int v);
    m_code = m_cand;
    m_held = 1;
    m_st   = 2;
    m_pfr  = 0;
    v      = 1;
  endtask

  // One whole frame seen with key set m
  task automatic model_frame(input logic [15:0] m, output int v);
    int  code;
    bit  hit;
    bit  seen;
    v    = 0;
    hit  = (m != 0);
    code = 0;
    for (int c = 3; c >= 0; c--)
      for (int r = 3; r >= 0; r--)
        if (m[r*4+c]) code = r*4 + c;
    seen = m[m_cand];
    case (m_st)
      0: if (hit) begin
        m_cand = code;
        if (DF == 1) model_accept(v);
        else begin m_cnt = 1; m_st = 1; end
      end
      1: if (!seen) begin
        m_st = 0; m_cnt = 0;
      end else if (m_cnt + 1 >= DF) model_accept(v);
      else m_cnt++;
      2: if (!seen) begin
        if (DF == 1) begin m_st = 0; m_held = 0; end
        else begin m_cnt = 1; m_st = 3; end
      end else begin
`ifdef KEYPAD_REPEAT_EN
        m_pfr++;
        if (m_pfr == RD || (m_pfr > RD && (m_pfr - RD) % RR == 0))
          v = 1;
`endif
      end
      default: if (seen) m_st = 2;
      else if (m_cnt + 1 >= DF) begin
        m_st = 0; m_held = 0; m_cnt = 0;
      end else m_cnt++;
    endcase
  endtask

  // Drive key set m for one frame and check every cycle of it
  task automatic run_frame(input logic [15:0] m);
    int   v_exp;
    int   stray;
    logic [3:0] ec;
    keys  = m;
    stray = 0;
    model_frame(m, v_exp);
    for (int j = 1; j <= 16; j++) begin
      @(posedge CLK);
      #1;
      ec = 4'b1111 ^ (4'b0001 << ((j % 16) / 4));
      chk("key_col", {28'd0, KEY_COL}, {28'd0, ec});
      if (j < 16) stray += int'(KEY_VALID);
    end
    dut_pulses += int'(KEY_VALID);
    chk("stray_valid", stray, 0);
    chk("valid", {31'd0, KEY_VALID}, v_exp);
    chk("held", {31'd0, KEY_HELD}, m_held);
    chk("code", {28'd0, KEY_CODE}, m_code);
  endtask

  task automatic frames(input logic [15:0] m, input int n);
    for (int i = 0; i < n; i++) run_frame(m);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    #1;
    model_reset();
    chk("rst_col", {28'd0, KEY_COL}, 32'hE);
    chk("rst_code", {28'd0, KEY_CODE}, 0);
    chk("rst_valid", {31'd0, KEY_VALID}, 0);
    chk("rst_held", {31'd0, KEY_HELD}, 0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    int p0;
    logic [15:0] m;
    model_reset();
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_col", {28'd0, KEY_COL}, 32'hE);
    chk("rst_code", {28'd0, KEY_CODE}, 0);
    chk("rst_valid", {31'd0, KEY_VALID}, 0);
    chk("rst_held", {31'd0, KEY_HELD}, 0);
    @(negedge CLK);
    RST = 1'b0;

    // Idle scan
    frames(16'h0000, 3);
    chk("idle_pulses", dut_pulses, 0);

    // Clean press of key 9, then release
    p0 = dut_pulses;
    frames(16'h0200, 10);
    chk("press_pulses", dut_pulses - p0, 1);
    chk("press_code", {28'd0, KEY_CODE}, 9);
    frames(16'h0000, 2);
    chk("rel_held_2", {31'd0, KEY_HELD}, 1);
    frames(16'h0000, 1);
    chk("rel_held_3", {31'd0, KEY_HELD}, 0);
    frames(16'h0000, 1);

    // Bounce on key 5 must be rejected
    p0 = dut_pulses;
    frames(16'h0020, 2);
    frames(16'h0000, 1);
    frames(16'h0020, 2);
    frames(16'h0000, 4);
    chk("bounce_pulses", dut_pulses - p0, 0);
    chk("bounce_held", {31'd0, KEY_HELD}, 0);

    // Keys 6 and 3 together: column 2 scanned first, so 6 wins
    p0 = dut_pulses;
    frames(16'h0048, 5);
    chk("simul_code", {28'd0, KEY_CODE}, 6);
    frames(16'h0049, 4);
    chk("simul_pulses", dut_pulses - p0, 1);
    frames(16'h0000, 4);

    // Reset during debounce of key 12
    p0 = dut_pulses;
    frames(16'h1000, 2);
    do_reset();
    chk("midrst_pulses", dut_pulses - p0, 0);
    frames(16'h1000, 2);
    chk("midrst_early", dut_pulses - p0, 0);
    frames(16'h1000, 1);
    chk("midrst_accept", dut_pulses - p0, 1);
    chk("midrst_code", {28'd0, KEY_CODE}, 12);
    frames(16'h0000, 4);

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat on key 15
    p0 = dut_pulses;
    frames(16'h8000, 14);
    chk("rpt_pulses", dut_pulses - p0, 5);
    chk("rpt_code", {28'd0, KEY_CODE}, 15);
    frames(16'h0000, 4);
`endif

    // Random key patterns held for random frame counts
    for (int n = 0; n < 30; n++) begin
      m = '0;
      if ($urandom_range(0, 9) >= 3) begin
        m[$urandom_range(0, 15)] = 1'b1;
        if ($urandom_range(0, 3) == 0) m[$urandom_range(0, 15)] = 1'b1;
      end
      frames(m, $urandom_range(1, 5));
    end
    frames(16'h0000, 4);
    chk("final_held", {31'd0, KEY_HELD}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
